// File: rtl/block_stamp.sv
// ============================================================================
// Module      : block_stamp
// Description : Stamps a 3x3 block bitmap into the board row RAM at (pos_x,
//               pos_y) by read-modify-write, one board row at a time. Reports
//               whether any stamped cell was already occupied.
//               Optional build macro BLOCK_STAMP_CLEAR_EN enables an erase
//               operation selected by op_clear.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high
//   start    in   stamp request, accepted only while idle
//   op_clear in   1 = erase block cells (BLOCK_STAMP_CLEAR_EN builds only)
//   block    in   [0:8] bitmap, bit r*3+c = block row r, column c
//   pos_x    in   board column of block column 0
//   pos_y    in   board row of block row 0
//   rd_addr  out  row RAM read address
//   rd_data  in   row RAM read data, valid one cycle after rd_addr
//   wr_en    out  row RAM write strobe
//   wr_addr  out  row RAM write address
//   wr_data  out  row RAM write data
//   busy     out  high from the cycle after accept through the done cycle
//   done     out  one-cycle completion pulse
//   collide  out  overlap flag, valid with done, held until next accept
// ============================================================================
`default_nettype none

module block_stamp #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op_clear,
    input  logic [0:8]         block,
    input  logic [3:0]         pos_x,
    input  logic [3:0]         pos_y,
    output logic [3:0]         rd_addr,
    input  logic [0:BOARD_W-1] rd_data,
    output logic               wr_en,
    output logic [3:0]         wr_addr,
    output logic [0:BOARD_W-1] wr_data,
    output logic               busy,
    output logic               done,
    output logic               collide
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [0:8]         blk;
    logic [3:0]         px;
    logic [3:0]         py;
    logic [1:0]         row;
    logic               acc;
    logic               collide_q;

    logic [4:0]         row_addr;
    logic               row_ok;
    logic [0:2]         row_bits;
    logic [0:BOARD_W+1] ext;
    logic [0:BOARD_W+1] shifted;
    logic [0:BOARD_W-1] mask;
    logic               is_clear;
    logic               hit;

`ifdef BLOCK_STAMP_CLEAR_EN
    logic op;

    always_ff @(posedge clk) begin
        if (reset) begin
            op <= 1'b0;
        end else if (state == S_IDLE && start) begin
            op <= op_clear;
        end
    end

    assign is_clear = op;
`else
    logic unused_op_clear;

    assign unused_op_clear = op_clear;
    assign is_clear        = 1'b0;
`endif

    // Board row being processed, 5 bits so rows past the bottom edge are
    // detected rather than wrapping back onto the board.
    assign row_addr = {1'b0, py} + {3'b000, row};
    assign row_ok   = (row_addr < 5'(BOARD_H));

    always_comb begin
        row_bits = blk[6:8];
        case (row)
            2'd0:    row_bits = blk[0:2];
            2'd1:    row_bits = blk[3:5];
            default: row_bits = blk[6:8];
        endcase
    end

    // With [0:N] ordering a right shift moves bits toward higher column
    // indices; block cells landing on columns >= BOARD_W fall into the two
    // spare bits or off the end and are dropped, so nothing wraps.
    assign ext     = {row_bits, {(BOARD_W - 1){1'b0}}};
    assign shifted = ext >> px;
    assign mask    = shifted[0:BOARD_W-1];

    // Stamping collides on an already-set cell; erasing collides on an
    // already-clear one.
    assign hit = is_clear ? |(~rd_data & mask) : |(rd_data & mask);

    always_comb begin
        rd_addr = 4'd0;
        wr_addr = 4'd0;
        wr_data = '0;
        wr_en   = 1'b0;
        if (state == S_RD && row_ok) begin
            rd_addr = row_addr[3:0];
        end
        if (state == S_WR) begin
            wr_data = is_clear ? (rd_data & ~mask) : (rd_data | mask);
            wr_en   = row_ok && (|mask);
            if (row_ok) begin
                wr_addr = row_addr[3:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RD;
            S_RD:    state_nx = S_WR;
            S_WR:    state_nx = (row == 2'd2) ? S_DONE : S_RD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            blk       <= '0;
            px        <= 4'd0;
            py        <= 4'd0;
            row       <= 2'd0;
            acc       <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                blk       <= block;
                px        <= pos_x;
                py        <= pos_y;
                row       <= 2'd0;
                acc       <= 1'b0;
                collide_q <= 1'b0;
            end else if (state == S_WR) begin
                acc <= acc | (wr_en & hit);
                if (row == 2'd2) begin
                    collide_q <= acc | (wr_en & hit);
                end else begin
                    row <= row + 2'd1;
                end
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign collide = collide_q;

endmodule

`default_nettype wire

// File: tb/tb_block_stamp.sv
// ============================================================================
// Module      : tb_block_stamp
// Description : Scoreboard bench for block_stamp. Stimulus tasks push the
//               expected RAM writes and done/collide results; a negedge
//               monitor pops and compares whenever the DUT writes or signals
//               done. A small row RAM model answers the DUT's reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_stamp;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op_clear;
    logic [0:8] block;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [3:0] rd_addr;
    logic [0:9] rd_data;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [0:9] wr_data;
    logic       busy;
    logic       done;
    logic       collide;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0] addr;
        logic [0:9] data;
    } wr_t;

    typedef struct {
        int   cycle;
        logic col;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    logic [0:9] ram [0:9];

    block_stamp #(.BOARD_W(10), .BOARD_H(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_clear (op_clear),
        .block    (block),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .collide  (collide)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data <= (rd_addr < 4'd10) ? ram[rd_addr] : 10'b0;
        if (wr_en && wr_addr < 4'd10) ram[wr_addr] <= wr_data;
    end

    // Monitor: compare DUT writes and done pulses against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        dn_t d;
        if (!reset) begin
            if (rd_addr > 4'd9 || wr_addr > 4'd9) begin
                n_fail++;
                $display("FAIL addr_range: rd_addr=%0d wr_addr=%0d, required <= 9", rd_addr, wr_addr);
            end
            if (wr_en) begin
                n_tests++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%0d data=%b, required no write", wr_addr, wr_data);
                end else begin
                    e = wq.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        n_fail++;
                        $display("FAIL write: got addr=%0d data=%b, required addr=%0d data=%b",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
            if (done) begin
                n_tests++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: at cycle %0d, required no done", cyc);
                end else begin
                    d = dq.pop_front();
                    if (cyc != d.cycle || collide !== d.col || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL done: got cycle=%0d collide=%b busy=%b, required cycle=%0d collide=%b busy=1",
                                 cyc, collide, busy, d.cycle, d.col);
                    end
                end
            end
        end
    end

    task automatic push_wr(input logic [3:0] a, input logic [0:9] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if ({rd_addr, wr_addr, wr_data, wr_en, busy, done, collide} !== 24'd0) begin
            n_fail++;
            $display("FAIL %s: got rd=%0d wa=%0d wd=%b we=%b busy=%b done=%b col=%b, required all 0",
                     name, rd_addr, wr_addr, wr_data, wr_en, busy, done, collide);
        end
    endtask

    // Issue one stamp. pulse_at / rst_at give the T+k cycle (relative to the
    // accept cycle T) for a stray start pulse or a reset; -1 disables.
    task automatic stamp(input logic [0:8] b, input logic [3:0] x, input logic [3:0] y,
                         input logic op, input logic exp_col,
                         input int pulse_at, input int rst_at);
        int  a;
        int  k;
        dn_t d;
        @(negedge clk);
        block    = b;
        pos_x    = x;
        pos_y    = y;
        op_clear = op;
        start    = 1'b1;
        @(negedge clk);
        // Scramble inputs: the DUT must use its latched copies.
        start    = 1'b0;
        block    = ~b;
        pos_x    = x + 4'd1;
        pos_y    = y + 4'd1;
        op_clear = ~op;
        a = cyc;          // this negedge lies in cycle T+1
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_accept: got %b, required 1", busy);
        end
        if (rst_at >= 0) begin
            repeat (rst_at - 2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check_idle("reset_abort");
            reset = 1'b0;
            return;
        end
        d.cycle = a + 6;  // done in cycle T+7
        d.col   = exp_col;
        dq.push_back(d);
        if (pulse_at >= 0) begin
            repeat (pulse_at - 2) @(negedge clk);
            start = 1'b1;
            block = 9'b111_111_111;
            pos_x = 4'd0;
            pos_y = 4'd0;
            @(negedge clk);
            start = 1'b0;
        end
        for (k = 0; k < 20; k++) begin
            if (done) break;
            @(negedge clk);
        end
        if (k == 20) begin
            n_fail++;
            $display("FAIL done_timeout: no done within 20 cycles, required done");
        end
        @(negedge clk);
        n_tests++;
        if (collide !== exp_col || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_hold: got collide=%b busy=%b, required collide=%b busy=0",
                     collide, busy, exp_col);
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) ram[i] = 10'b0;
        reset    = 1'b1;
        start    = 1'b0;
        op_clear = 1'b0;
        block    = 9'b0;
        pos_x    = 4'd0;
        pos_y    = 4'd0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset = 1'b0;

        // Block rows: 010 -> col 4, 111 -> cols 3..5, 000 -> no write.
        push_wr(4'd0, 10'b0000100000);
        push_wr(4'd1, 10'b0001110000);
        stamp(9'b010_111_000, 4'd3, 4'd0, 1'b0, 1'b0, -1, -1);

        // Same block again: same rows, all cells already set.
        push_wr(4'd0, 10'b0000100000);
        push_wr(4'd1, 10'b0001110000);
        stamp(9'b010_111_000, 4'd3, 4'd0, 1'b0, 1'b1, -1, -1);

`ifdef BLOCK_STAMP_CLEAR_EN
        push_wr(4'd0, 10'b0000000000);
        push_wr(4'd1, 10'b0000000000);
        stamp(9'b010_111_000, 4'd3, 4'd0, 1'b1, 1'b0, -1, -1);
        push_wr(4'd0, 10'b0000000000);
        push_wr(4'd1, 10'b0000000000);
        stamp(9'b010_111_000, 4'd3, 4'd0, 1'b1, 1'b1, -1, -1);
`else
        // op_clear has no effect in this build: plain stamp, collides.
        push_wr(4'd0, 10'b0000100000);
        push_wr(4'd1, 10'b0001110000);
        stamp(9'b010_111_000, 4'd3, 4'd0, 1'b1, 1'b1, -1, -1);
`endif

        // Bottom-right corner: cols 10 and row 10 clipped.
        push_wr(4'd8, 10'b0000000011);
        push_wr(4'd9, 10'b0000000011);
        stamp(9'b111_111_111, 4'd8, 4'd8, 1'b0, 1'b0, -1, -1);

        // Column clipping at x=8 plus a stray start at T+3.
        push_wr(4'd6, 10'b0000000001);
        stamp(9'b011_000_000, 4'd8, 4'd6, 1'b0, 1'b0, 3, -1);

        // Only non-empty row falls off the board: no writes at all.
        stamp(9'b000_111_000, 4'd0, 4'd9, 1'b0, 1'b0, -1, -1);

        // Single cell onto row 1, col 4.
`ifdef BLOCK_STAMP_CLEAR_EN
        push_wr(4'd1, 10'b0000100000);
        stamp(9'b100_000_000, 4'd4, 4'd1, 1'b0, 1'b0, -1, -1);
`else
        push_wr(4'd1, 10'b0001110000);
        stamp(9'b100_000_000, 4'd4, 4'd1, 1'b0, 1'b1, -1, -1);
`endif

        // Reset at T+4: row 3 already written, no done.
        push_wr(4'd3, 10'b1110000000);
        stamp(9'b111_000_000, 4'd0, 4'd3, 1'b0, 1'b0, -1, 4);

        // Fresh start after reset, all-zero block.
        stamp(9'b000_000_000, 4'd2, 4'd2, 1'b0, 1'b0, -1, -1);

        n_tests++;
        if (wq.size() != 0 || dq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d writes %0d dones pending, required 0 and 0",
                     wq.size(), dq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
